bidirectional_spi_engine: RTL
=============================

Name: bidirectional_spi_engine

Overview:
- Parametrised 3-wire (half-duplex, single SDIO) SPI master engine for OCRA peripheral configuration, e.g. ADC/DAC/synth chips with shared SDIO.
- Runs one transaction of 1..MAX_BITS bits per start request. A per-bit direction mask selects drive or sample on each bit.
- Supports all four CPOL/CPHA modes, a runtime SCLK divider, and abort.
- Sits between the AXI register slave, which supplies the request fields, and the IO pad.

Parameters:
- MAX_BITS, 32, maximum bits per transaction; also the width of the data, mask and read buses.
- LEN_W, 8, width of the length field.
- DIV_W, 8, width of the SCLK divider field.

Ports:
- spi_clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- abort  in  1  one-cycle request to terminate the active transaction.
- transaction_length  in  LEN_W  number of bits to transfer.
- transaction_data  in  MAX_BITS  write data; bit length-1 is sent first.
- transaction_rw_mask  in  MAX_BITS  per bit: 1 = master drives, 0 = master samples.
- clk_div  in  DIV_W  half-period H = clk_div+1 spi_clk cycles.
- spi_cpol  in  1  SCLK idle level.
- spi_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- len_err  out  1  one-cycle pulse when start is given with length 0 or length > MAX_BITS.
- transaction_read_data  out  MAX_BITS  sampled bits, right-aligned.
- spi_sdio  inout  1  bidirectional data pad.
- spi_sclk  out  1  SPI clock.
- spi_cs_n  out  1  chip select, active low.

Behaviour:
- Reset values: busy=0, done=0, aborted=0, len_err=0, transaction_read_data=0, spi_cs_n=1, spi_sclk=0, SDIO driver disabled (high-Z), FSM=IDLE.
- Reset mid-transaction takes effect immediately: CS rises and SDIO releases asynchronously.
- IDLE:
  - spi_sclk follows spi_cpol, registered.
  - On start with a valid length: latch length, data, mask, cpol, cpha and div; clear read_data; set busy=1 and cs_n=0 next cycle; go to SETUP.
  - On start with an invalid length: pulse len_err; no bus activity; stay IDLE.
- Start while busy=1 is ignored. Inputs changing during a transaction have no effect; all fields are latched.
- Bit k is the index sequence length-1 down to 0.
  - When mask[k]=1, SDIO drives data[k].
  - When mask[k]=0, SDIO is high-Z and the sampled pad value is shifted into read_data LSB.
  - Bits with mask=1 shift in 0.
- After N bits, read_data[N-1:0] holds the bits in transfer order; upper bits are 0.
- SETUP (1 half-period):
  - CPHA=0: bit length-1 is presented (driven or released) at SETUP entry.
  - CPHA=1: SDIO stays as in idle (high-Z).
- SHIFT (2·length half-periods): SCLK toggles at the end of each half-period.
  - CPHA=0: sample on leading edges; present the next bit on trailing edges, except after the last bit.
  - CPHA=1: present on leading edges; sample on trailing edges.
  - The SDIO driver enable changes only on the same edge as the data change, so a bus turnaround costs no extra cycles.
- HOLD (1 half-period): SCLK back at cpol; SDIO released.
- Then cs_n=1 and GAP (1 half-period, CS high) follows.
- Completion: busy falls, done pulses in the same cycle, and read_data is valid from that cycle, held until the next accepted start.
- CS low duration is exactly (2·length+2)·H cycles.
- Half-period counter: counts 0..clk_div, then reloads. With clk_div=0, SCLK toggles every cycle.
- Abort, when busy:
  - At the next half-period boundary, SCLK returns to cpol, SDIO releases and cs_n=1.
  - Then GAP runs; busy falls with an aborted pulse and no done. read_data holds the partial bits.
  - Abort in IDLE is ignored. Start and abort in the same cycle in IDLE: start wins.
- Sampling is the spi_clk-registered pad value taken in the cycle the sampling edge is issued.

Test Plan:
- Mode 0, length=8, data=0xA5, mask=0xFF, clk_div=0 -> SDIO carries 1,0,1,0,0,1,0,1 on rising edges; cs_n low exactly 18 cycles; one done pulse; read_data=0.
- Mode 3, length=16, mask=0xFF00, data=0x8000, slave model returns 0x3C on the read byte, clk_div=3 -> first byte 0x80 driven; SDIO high-Z from bit 7; read_data=0x003C; cs_n low 136 cycles.
- length=0, then length=MAX_BITS+1 -> len_err pulses twice; cs_n stays 1; busy stays 0.
- Abort after 5 SCLK edges of a 24-bit read -> CS rises at the next half-period boundary; aborted pulses, no done; the next start runs normally.
- Async reset asserted mid-SHIFT in mode 2 -> cs_n=1 and SDIO high-Z with no clock edge; all outputs at reset values.
- Start held high for 3 cycles, plus a start during busy -> exactly one transaction; clk_div changed mid-transfer does not alter SCLK period.

Source files
------------

// File: rtl/bidirectional_spi_engine.sv
// 3-wire half-duplex SPI master: one transaction of 1..MAX_BITS bits per start,
// per-bit drive/sample direction, all CPOL/CPHA modes, runtime SCLK divider and abort.
module bidirectional_spi_engine #(
  parameter int MAX_BITS = 32,
  parameter int LEN_W    = 8,
  parameter int DIV_W    = 8
) (
  input  logic                spi_clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    transaction_length,
  input  logic [MAX_BITS-1:0] transaction_data,
  input  logic [MAX_BITS-1:0] transaction_rw_mask,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic                spi_cpol,
  input  logic                spi_cpha,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                len_err,
  output logic [MAX_BITS-1:0] transaction_read_data,
  inout  wire                 spi_sdio,
  output logic                spi_sclk,
  output logic                spi_cs_n
);
  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state_reg, state_next;

  logic [LEN_W-1:0]    len_reg;
  logic [MAX_BITS-1:0] data_reg, mask_reg, read_reg;
  logic                cpol_reg, cpha_reg;
  logic [DIV_W-1:0]    div_reg, hp_cnt_reg;
  logic [LEN_W:0]      edge_cnt_reg;
  logic [IDX_W-1:0]    bit_idx_reg;
  logic                sclk_reg, sdio_oe_reg, sdio_out_reg, pad_reg, abort_reg;
  logic                cs_n_reg, busy_reg, done_reg, aborted_reg, len_err_reg;

  logic             len_ok, accept, active, hp_end, abort_req, last_edge, lead;
  logic             shift_edge, do_sample, do_present, dec_idx, to_gap, finish;
  logic [IDX_W-1:0] start_idx, present_idx;

  always_comb begin
    len_ok      = (transaction_length != '0) && (int'(transaction_length) <= MAX_BITS);
    accept      = (state_reg == IDLE) && start && len_ok;
    active      = (state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD);
    hp_end      = (hp_cnt_reg == div_reg);
    abort_req   = active && (abort_reg || abort);
    last_edge   = (edge_cnt_reg == ({len_reg, 1'b0} - (LEN_W+1)'(1)));
    lead        = ~edge_cnt_reg[0];
    shift_edge  = (state_reg == SHIFT) && hp_end && !abort_req;
    // Leading edges sample in CPHA=0, trailing edges sample in CPHA=1.
    do_sample   = shift_edge && (lead ^ cpha_reg);
    do_present  = shift_edge && (cpha_reg ? lead : (!lead && !last_edge));
    dec_idx     = shift_edge && !lead && !last_edge;
    start_idx   = IDX_W'(transaction_length - LEN_W'(1));
    present_idx = cpha_reg ? bit_idx_reg : (bit_idx_reg - IDX_W'(1));

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (hp_end) state_next = abort_req ? GAP : SHIFT;
      SHIFT:   if (hp_end) state_next = abort_req ? GAP : (last_edge ? HOLD : SHIFT);
      HOLD:    if (hp_end) state_next = GAP;
      GAP:     if (hp_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    to_gap = (state_next == GAP) && (state_reg != GAP);
    finish = (state_reg == GAP) && hp_end;
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      len_reg      <= '0;
      data_reg     <= '0;
      mask_reg     <= '0;
      read_reg     <= '0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      div_reg      <= '0;
      hp_cnt_reg   <= '0;
      edge_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      sclk_reg     <= 1'b0;
      sdio_oe_reg  <= 1'b0;
      sdio_out_reg <= 1'b0;
      pad_reg      <= 1'b0;
      abort_reg    <= 1'b0;
      cs_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      len_err_reg  <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      len_err_reg <= 1'b0;
      pad_reg     <= spi_sdio;
      if (state_reg == IDLE) begin
        sclk_reg     <= spi_cpol;
        len_err_reg  <= start && !len_ok;
        hp_cnt_reg   <= '0;
        edge_cnt_reg <= '0;
        if (accept) begin
          len_reg     <= transaction_length;
          data_reg    <= transaction_data;
          mask_reg    <= transaction_rw_mask;
          cpol_reg    <= spi_cpol;
          cpha_reg    <= spi_cpha;
          div_reg     <= clk_div;
          read_reg    <= '0;
          abort_reg   <= 1'b0;
          busy_reg    <= 1'b1;
          cs_n_reg    <= 1'b0;
          bit_idx_reg <= start_idx;
          // CPHA=0 presents the first bit as CS falls.
          if (!spi_cpha) begin
            sdio_oe_reg  <= transaction_rw_mask[start_idx];
            sdio_out_reg <= transaction_data[start_idx];
          end
        end
      end else begin
        hp_cnt_reg <= hp_end ? '0 : (hp_cnt_reg + DIV_W'(1));
        if (active) abort_reg <= abort_reg | abort;
        if (shift_edge) begin
          sclk_reg     <= ~sclk_reg;
          edge_cnt_reg <= edge_cnt_reg + (LEN_W+1)'(1);
          if (last_edge) sdio_oe_reg <= 1'b0;
        end
        if (do_sample)
          read_reg <= {read_reg[MAX_BITS-2:0], mask_reg[bit_idx_reg] ? 1'b0 : pad_reg};
        if (dec_idx) bit_idx_reg <= bit_idx_reg - IDX_W'(1);
        if (do_present) begin
          sdio_oe_reg  <= mask_reg[present_idx];
          sdio_out_reg <= data_reg[present_idx];
        end
        if (to_gap) begin
          sclk_reg    <= cpol_reg;
          sdio_oe_reg <= 1'b0;
          cs_n_reg    <= 1'b1;
        end
        if (finish) begin
          busy_reg    <= 1'b0;
          done_reg    <= !abort_reg;
          aborted_reg <= abort_reg;
        end
      end
    end
  end

  assign spi_sdio              = sdio_oe_reg ? sdio_out_reg : 1'bz;
  assign spi_sclk              = sclk_reg;
  assign spi_cs_n              = cs_n_reg;
  assign busy                  = busy_reg;
  assign done                  = done_reg;
  assign aborted               = aborted_reg;
  assign len_err               = len_err_reg;
  assign transaction_read_data = read_reg;

endmodule
